// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared CHIP-8 widths, program start address and fetch FSM states
package chip8_pkg;

  localparam int          CHIP8_ADDR_W     = 12;
  localparam int          CHIP8_OPCODE_W   = 16;
  localparam logic [11:0] CHIP8_PROG_START = 12'h200;

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    HOLD     = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/chip8_fetch_if.sv
// rtl/chip8_fetch_if.sv - program-memory read port plus opcode valid/ready channel of the fetch stage
interface chip8_fetch_if
  import chip8_pkg::*;
#(
  parameter int ADDR_W = CHIP8_ADDR_W
);

  logic [ADDR_W-1:0]         mem_addr;
  logic [7:0]                mem_data;
  logic                      opcode_valid;
  logic                      opcode_ready;
  logic [CHIP8_OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0]         opcode_pc;

  // master is the fetch stage; slave is memory plus decode
  modport master (
    output mem_addr,
    input  mem_data,
    output opcode_valid,
    input  opcode_ready,
    output opcode,
    output opcode_pc
  );

  modport slave (
    input  mem_addr,
    output mem_data,
    input  opcode_valid,
    output opcode_ready,
    input  opcode,
    input  opcode_pc
  );

endinterface

// File: rtl/chip8_fetch.sv
// rtl/chip8_fetch.sv - two-byte big-endian opcode fetch with PC ownership and jump redirect
module chip8_fetch
  import chip8_pkg::*;
#(
  parameter int                ADDR_W   = CHIP8_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CHIP8_PROG_START)
) (
  input  logic              clk,
  input  logic              rst,
  chip8_fetch_if.master     bus,
  input  logic              halt,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_e              state_q, state_d;
  logic [ADDR_W-1:0]         pc_q, pc_d;
  logic [7:0]                hi_q, hi_d;
  logic [CHIP8_OPCODE_W-1:0] opcode_q, opcode_d;
  logic [ADDR_W-1:0]         opcode_pc_q, opcode_pc_d;
  logic                      valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH_HI;
      pc_q        <= RESET_PC;
      hi_q        <= 8'h00;
      opcode_q    <= '0;
      opcode_pc_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hi_q        <= hi_d;
      opcode_q    <= opcode_d;
      opcode_pc_q <= opcode_pc_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hi_d        = hi_q;
    opcode_d    = opcode_q;
    opcode_pc_d = opcode_pc_q;
    valid_d     = valid_q;

    unique case (state_q)
      FETCH_HI: begin
        if (!halt) begin
          hi_d    = bus.mem_data;
          state_d = FETCH_LO;
        end
      end
      // halt is deliberately not consulted: an in-flight fetch always completes
      FETCH_LO: begin
        opcode_d    = {hi_q, bus.mem_data};
        opcode_pc_d = pc_q;
        pc_d        = pc_q + ADDR_W'(2);
        valid_d     = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.opcode_ready) begin
          valid_d = 1'b0;
          state_d = FETCH_HI;
        end
      end
      default: begin
        state_d = FETCH_HI;
        valid_d = 1'b0;
      end
    endcase

    // redirect wins over halt and over any partial fetch; a coincident accept still happened
    if (pc_load) begin
      pc_d    = pc_load_val;
      state_d = FETCH_HI;
      valid_d = 1'b0;
    end
  end

  assign bus.mem_addr     = (state_q == FETCH_LO) ? pc_q + ADDR_W'(1) : pc_q;
  assign bus.opcode       = opcode_q;
  assign bus.opcode_pc    = opcode_pc_q;
  assign bus.opcode_valid = valid_q;
  assign pc               = pc_q;

endmodule

// File: tb/tb_chip8_fetch.sv
// tb/tb_chip8_fetch.sv - directed bench for chip8_fetch against a combinational byte memory
module tb_chip8_fetch;

  logic        clk;
  logic        rst;
  logic        halt;
  logic        pc_load;
  logic [11:0] pc_load_val;
  logic [11:0] pc;
  logic [7:0]  mem [0:4095];

  int checks;
  int errors;

  chip8_fetch_if #(.ADDR_W(12)) bus ();

  chip8_fetch #(.ADDR_W(12), .RESET_PC(12'h200)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .halt        (halt),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .pc          (pc)
  );

  assign bus.mem_data = mem[bus.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    halt        = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = 12'h000;
    bus.opcode_ready = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    // reset state
    mem[12'h200] = 8'h00;
    mem[12'h201] = 8'hE0;
    do_reset();
    chk("rst_valid",     32'(bus.opcode_valid), 32'h0);
    chk("rst_pc",        32'(pc),               32'h200);
    chk("rst_opcode",    32'(bus.opcode),       32'h0);
    chk("rst_opcode_pc", 32'(bus.opcode_pc),    32'h0);
    chk("rst_mem_addr",  32'(bus.mem_addr),     32'h200);

    // first opcode two cycles after reset
    step();
    chk("lo_valid",    32'(bus.opcode_valid), 32'h0);
    chk("lo_mem_addr", 32'(bus.mem_addr),     32'h201);
    step();
    chk("first_valid",     32'(bus.opcode_valid), 32'h1);
    chk("first_opcode",    32'(bus.opcode),       32'h00E0);
    chk("first_opcode_pc", 32'(bus.opcode_pc),    32'h200);
    chk("first_pc",        32'(pc),               32'h202);

    // stream of three opcodes, one every three cycles
    mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
    mem[12'h202] = 8'h56; mem[12'h203] = 8'h78;
    mem[12'h204] = 8'h9A; mem[12'h205] = 8'hBC;
    do_reset();
    begin
      logic [15:0] exp_ops [3];
      exp_ops[0] = 16'h1234; exp_ops[1] = 16'h5678; exp_ops[2] = 16'h9ABC;
      for (int k = 0; k < 3; k++) begin
        step();
        chk("stream_lo_valid", 32'(bus.opcode_valid), 32'h0);
        step();
        chk("stream_valid",     32'(bus.opcode_valid), 32'h1);
        chk("stream_opcode",    32'(bus.opcode),       32'(exp_ops[k]));
        chk("stream_opcode_pc", 32'(bus.opcode_pc),    32'h200 + 32'(2 * k));
        step();
        chk("stream_accepted", 32'(bus.opcode_valid), 32'h0);
      end
    end
    chk("stream_pc_end", 32'(pc), 32'h206);

    // backpressure in HOLD
    bus.opcode_ready = 1'b0;
    do_reset();
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_valid",     32'(bus.opcode_valid), 32'h1);
      chk("hold_opcode",    32'(bus.opcode),       32'h1234);
      chk("hold_opcode_pc", 32'(bus.opcode_pc),    32'h200);
      chk("hold_mem_addr",  32'(bus.mem_addr),     32'h202);
      chk("hold_pc",        32'(pc),               32'h202);
    end
    bus.opcode_ready = 1'b1;
    step();
    chk("hold_accept_valid", 32'(bus.opcode_valid), 32'h0);
    chk("hold_accept_pc",    32'(pc),               32'h202);
    step();
    step();
    chk("hold_next_opcode", 32'(bus.opcode), 32'h5678);

    // redirect during FETCH_LO
    mem[12'h300] = 8'h6A;
    mem[12'h301] = 8'h55;
    do_reset();
    step();
    chk("redir_in_lo", 32'(bus.mem_addr), 32'h201);
    pc_load     = 1'b1;
    pc_load_val = 12'h300;
    step();
    pc_load = 1'b0;
    chk("redir_valid",    32'(bus.opcode_valid), 32'h0);
    chk("redir_pc",       32'(pc),               32'h300);
    chk("redir_mem_addr", 32'(bus.mem_addr),     32'h300);
    step();
    chk("redir_lo_valid", 32'(bus.opcode_valid), 32'h0);
    step();
    chk("redir_opcode",    32'(bus.opcode),    32'h6A55);
    chk("redir_opcode_pc", 32'(bus.opcode_pc), 32'h300);
    chk("redir_pc_next",   32'(pc),            32'h302);

    // redirect coinciding with an accept, to FFF, fetching across the wrap
    mem[12'hFFF] = 8'hA2;
    mem[12'h000] = 8'h2A;
    pc_load     = 1'b1;
    pc_load_val = 12'hFFF;
    step();
    pc_load = 1'b0;
    chk("wrap_valid", 32'(bus.opcode_valid), 32'h0);
    chk("wrap_pc",    32'(pc),               32'hFFF);
    step();
    chk("wrap_lo_addr", 32'(bus.mem_addr), 32'h000);
    step();
    chk("wrap_opcode",    32'(bus.opcode),    32'hA22A);
    chk("wrap_opcode_pc", 32'(bus.opcode_pc), 32'hFFF);
    chk("wrap_pc_next",   32'(pc),            32'h001);

    // FFE wraps to 000
    pc_load     = 1'b1;
    pc_load_val = 12'hFFE;
    step();
    pc_load = 1'b0;
    step();
    step();
    chk("wrap2_pc", 32'(pc), 32'h000);

    // halt raised in HOLD: held opcode stays valid, then FSM parks
    bus.opcode_ready = 1'b0;
    halt             = 1'b1;
    step();
    chk("halt_hold_valid", 32'(bus.opcode_valid), 32'h1);
    bus.opcode_ready = 1'b1;
    step();
    chk("halt_accept_valid", 32'(bus.opcode_valid), 32'h0);
    step();
    chk("halt_park_addr",  32'(bus.mem_addr),     32'h000);
    chk("halt_park_valid", 32'(bus.opcode_valid), 32'h0);
    chk("halt_park_pc",    32'(pc),               32'h000);

    // redirect beats halt
    pc_load     = 1'b1;
    pc_load_val = 12'h200;
    step();
    pc_load = 1'b0;
    chk("halt_redir_pc", 32'(pc), 32'h200);

    // reset asserted mid-HOLD while halted
    halt             = 1'b0;
    bus.opcode_ready = 1'b0;
    step();
    step();
    chk("pre_rst_valid", 32'(bus.opcode_valid), 32'h1);
    halt = 1'b1;
    rst  = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(bus.opcode_valid), 32'h0);
    chk("mid_rst_pc",    32'(pc),               32'h200);
    chk("mid_rst_addr",  32'(bus.mem_addr),     32'h200);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("halted_addr",  32'(bus.mem_addr),     32'h200);
      chk("halted_valid", 32'(bus.opcode_valid), 32'h0);
    end
    halt = 1'b0;
    step();
    chk("unhalt_lo_addr", 32'(bus.mem_addr), 32'h201);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
